// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load; neither asserted means hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    if_id_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            // The pc field is left as-is; only instr/valid mark the bubble.
            slot_d.instr = NOP_INSTR;
            slot_d.valid = 1'b0;
        end else if (load) begin
            slot_d.instr = instr_i;
            slot_d.pc    = pc_i;
            slot_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q.instr <= NOP_INSTR;
            slot_q.pc    <= '0;
            slot_q.valid <= 1'b0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign instr_o = slot_q.instr;
    assign pc_o    = slot_q.pc;
    assign valid_o = slot_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALTED FSM, redirect/stall handling, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned MEM_BYTES    = 512,
    parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instruction,
    output logic [31:0] PC,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        misalign_err
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES) - 32'd4;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic         load, flush;
    logic         stalled_run;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        misalign_d  = 1'b0;
        load        = 1'b0;
        flush       = 1'b0;
        stalled_run = 1'b0;
        if (redirect) begin
            pc_d       = align_word(redirect_pc);
            flush      = 1'b1;
            state_d    = RUN;
            misalign_d = |redirect_pc[1:0];
        end else begin
            case (state_q)
                RUN: begin
                    // Stall outranks the range check; halting waits until stall drops.
                    if (stall) begin
                        stalled_run = 1'b1;
                    end else if (pc_q > LAST_ADDR) begin
                        state_d = HALTED;
                        flush   = 1'b1;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .flush  (flush),
        .instr_i(instruction),
        .pc_i   (pc_q),
        .instr_o(if_id_instr),
        .pc_o   (if_id_pc),
        .valid_o(if_id_valid)
    );

    assign PC           = pc_q;
    assign fetch_halted = (state_q == HALTED);
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (load ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (stalled_run ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    logic unused_stalled_run;
    assign unused_stalled_run = stalled_run;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc, instruction;
    logic [31:0] PC, if_id_instr, if_id_pc;
    logic        if_id_valid, fetch_halted, misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_VECTOR(32'h0000_0000),
        .MEM_BYTES   (512),
        .NOP_INSTR   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .PC          (PC),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .fetch_halted(fetch_halted),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .misalign_err(misalign_err)
    );

    always_comb begin
        if (PC < 32'd512) instruction = mem[PC[8:2]];
        else              instruction = 32'h0000_0000;
    end

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [6:0] idx;
        idx = addr[8:2];
        return mem[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc_exp,
                              input logic [31:0] ipc_exp, input logic valid_exp,
                              input logic [31:0] instr_exp);
        check({tag, "_PC"},    PC,                 pc_exp);
        check({tag, "_ifpc"},  if_id_pc,           ipc_exp);
        check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid_exp});
        check({tag, "_instr"}, if_id_instr,        instr_exp);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h2401_0002;
        mem[8] = 32'h0061_1818;

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        check_slot("reset", 32'h0, 32'h0, 1'b0, 32'h0);
        check("reset_halt", {31'd0, fetch_halted}, 32'd0);
        check("reset_mis",  {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("reset_fcnt", fetch_count, 32'd0);
        check("reset_scnt", stall_count, 32'd0);
`endif

        // Free run: 8 sequential fetches from the reset vector.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_slot("run", 32'(4 * (i + 1)), 32'(4 * i), 1'b1, word_at(32'(4 * i)));
        end
        check("run_first_word", mem[0], 32'h2401_0002);

        // Redirect to 8, one fetch, then stall three edges at PC=12.
        redirect = 1'b1; redirect_pc = 32'h8;
        step();
        check_slot("rd8", 32'h8, 32'd28, 1'b0, 32'h0);
        redirect = 1'b0;
        step();
        check_slot("pre_stall", 32'hC, 32'h8, 1'b1, word_at(32'h8));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_slot("stall", 32'hC, 32'h8, 1'b1, word_at(32'h8));
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_scnt", stall_count, 32'd3);
        check("stall_fcnt", fetch_count, 32'd9);
`endif
        stall = 1'b0;
        step();
        check_slot("resume1", 32'h10, 32'hC, 1'b1, word_at(32'hC));
        step();
        check_slot("resume2", 32'h14, 32'h10, 1'b1, word_at(32'h10));

        // Redirect together with stall: redirect wins, one bubble.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
        step();
        check_slot("rd20_bubble", 32'h20, 32'h10, 1'b0, 32'h0);
        check("rd20_mis", {31'd0, misalign_err}, 32'd0);
        stall = 1'b0; redirect = 1'b0;
        step();
        check_slot("rd20_target", 32'h24, 32'h20, 1'b1, 32'h0061_1818);

        // Misaligned redirect: aligned target, one-cycle error pulse.
        redirect = 1'b1; redirect_pc = 32'h1E;
        step();
        check("mis_PC",    PC, 32'h1C);
        check("mis_pulse", {31'd0, misalign_err}, 32'd1);
        check("mis_valid", {31'd0, if_id_valid},  32'd0);
        redirect = 1'b0;
        step();
        check("mis_clear", {31'd0, misalign_err}, 32'd0);
        check_slot("mis_target", 32'h20, 32'h1C, 1'b1, word_at(32'h1C));

        // Run off the end of memory and halt.
        redirect = 1'b1; redirect_pc = 32'h1F8;
        step();
        redirect = 1'b0;
        step();
        check_slot("end504", 32'h1FC, 32'h1F8, 1'b1, word_at(32'h1F8));
        step();
        check_slot("end508", 32'h200, 32'h1FC, 1'b1, word_at(32'h1FC));
        check("end508_halt", {31'd0, fetch_halted}, 32'd0);
        step();
        check("halt_flag",  {31'd0, fetch_halted}, 32'd1);
        check("halt_PC",    PC, 32'h200);
        check("halt_valid", {31'd0, if_id_valid}, 32'd0);
        stall = 1'b1;
        step();
        check("halt_stall_flag", {31'd0, fetch_halted}, 32'd1);
        check("halt_stall_PC",   PC, 32'h200);
        stall = 1'b0;
        step();
        check("halt_hold_flag",  {31'd0, fetch_halted}, 32'd1);
        check("halt_hold_valid", {31'd0, if_id_valid}, 32'd0);
        check("halt_hold_PC",    PC, 32'h200);

        // Redirect out of HALTED.
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        check("exit_halt", {31'd0, fetch_halted}, 32'd0);
        check("exit_PC",   PC, 32'h0);
        check("exit_valid", {31'd0, if_id_valid}, 32'd0);
        redirect = 1'b0;
        step();
        check_slot("exit_fetch", 32'h4, 32'h0, 1'b1, 32'h2401_0002);
        step();
        check_slot("pre_rst", 32'h8, 32'h4, 1'b1, word_at(32'h4));

        // Reset during a stall discards everything.
        stall = 1'b1; rst = 1'b0;
        step();
        check_slot("midrst", 32'h0, 32'h0, 1'b0, 32'h0);
        check("midrst_halt", {31'd0, fetch_halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("midrst_fcnt", fetch_count, 32'd0);
        check("midrst_scnt", stall_count, 32'd0);
`endif
        stall = 1'b0; rst = 1'b1;
        step();
        check_slot("post_rst", 32'h4, 32'h0, 1'b1, 32'h2401_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
